decoder_scan: RTL
=================

# decoder_scan

Parametrised registered one-hot decoder with a built-in scan sequencer. In DIRECT mode it decodes a handshaked select value into a one-hot output vector one cycle later. In SCAN mode it walks the one-hot bit across all outputs, holding each position for a programmable number of cycles. It drives row/strobe selects in the basics library and supersedes the fixed-width combinational decoders for any path that needs registered or sequenced selects.

## Interface
- `SEL_W`, default 3: select width; output width is `OUT_W = 2**SEL_W` (legal 1..6).
- `DWELL_W`, default 8: width of the dwell count.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  global enable; low forces IDLE and zero outputs.
- `mode`  in  1  0 = DIRECT, 1 = SCAN; sampled only in IDLE.
- `in_valid`  in  1  DIRECT-mode select strobe.
- `in_sel`  in  SEL_W  DIRECT-mode select value.
- `start`  in  1  SCAN start pulse.
- `stop`  in  1  SCAN stop pulse.
- `dwell`  in  DWELL_W  extra hold cycles per scan position; sampled at start.
- `out`  out  OUT_W  registered one-hot output; all-zero when inactive.
- `out_valid`  out  1  `out` holds a valid one-hot value.
- `cur_sel`  out  SEL_W  index of the set bit in `out` (0 when `out` = 0).
- `wrap`  out  1  one-cycle pulse when the scan wraps from `OUT_W-1` to 0.
- `busy`  out  1  high while in SCAN state.

## Operation
- Decode is true one-hot: select k sets exactly `out[k]`, for every k in 0..OUT_W-1. There are no reserved codes.
- States: IDLE, HOLD (DIRECT result latched), SCAN.
- IDLE:
  - `enable & mode==0 & in_valid` -> HOLD; `out <= 1<<in_sel`.
  - `enable & mode==1 & start & !stop` -> SCAN; `out <= 1`, `cur_sel <= 0`, dwell latched.
- HOLD: a new `in_valid` reloads `out` from `in_sel`. `start` is ignored. `mode` going to 1 with no `in_valid` -> IDLE, and `out` clears.
- SCAN:
  - The dwell counter counts 0..dwell_latched. At terminal count, `cur_sel` increments modulo OUT_W and the counter resets.
  - On increment from `OUT_W-1` to 0, `wrap` pulses for one cycle.
  - `in_valid`, `mode` and `start` are ignored.
  - `stop` -> IDLE, and `out` clears.
- `enable` low in any state -> IDLE next cycle; `out`, `out_valid`, `busy`, `cur_sel` go to 0 and the dwell counter clears.
- Priority: `rst` > `!enable` > `stop` > terminal-count advance > `start`/`in_valid`.
- Simultaneous `stop` and wrap: stop wins, so `wrap` does not pulse.
- `start` with `stop` in IDLE: stay in IDLE.
- `dwell` = 0: advance every cycle. `dwell` = 2**DWELL_W-1: hold 2**DWELL_W cycles. The counter never overflows.

## Timing
- Reset values: `out`=0, `out_valid`=0, `cur_sel`=0, `wrap`=0, `busy`=0, state IDLE, dwell counter 0.
- Reset mid-scan takes effect on the next edge, with no wrap pulse.
- DIRECT latency is 1 cycle: `in_valid` at edge N gives `out` and `out_valid` valid after edge N. Back-to-back `in_valid` updates every cycle.
- SCAN: `start` at edge N puts `out[0]` high after N. Each position lasts dwell+1 cycles. A full sweep takes OUT_W*(dwell+1) cycles.
- `wrap` is asserted in the same cycle that `out[0]` is re-entered.
- `stop` or `!enable` at edge N gives `out`=0 after N (1-cycle latency).
- `busy` = (state==SCAN), registered.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `decoder_pkg`: state enum (`DEC_IDLE`, `DEC_HOLD`, `DEC_SCAN`), mode constants (`DEC_MODE_DIRECT`=0, `DEC_MODE_SCAN`=1), and a `onehot` function (select -> one-hot, parametrised by width).
- Sub-module `decoder_dwell_timer` (DWELL_W counter with load, clear and terminal-count output) is instantiated once.
- The top level contains the FSM, the `cur_sel` register and the output register.

## Test plan
- DIRECT sweep, SEL_W=3: `in_valid` with `in_sel`=0..7 on consecutive cycles -> `out`=01,02,04,…,80 one cycle later each; `cur_sel` tracks; `out_valid`=1.
- SCAN, dwell=2: `start` -> each bit held 3 cycles in order 0..7; `wrap` pulses after 24 cycles as `out` returns to 01; `busy`=1 throughout.
- SCAN, dwell=0: `out` shifts every cycle. `stop` asserted in the same cycle as the 7->0 wrap -> `out`=0 next cycle, no `wrap` pulse, `busy`=0.
- Drop `enable` mid-HOLD and mid-SCAN -> all outputs 0 after one edge. Re-enable plus `start` restarts at `out`=01.
- Assert `rst` at scan position 5 -> all outputs at reset values next cycle. `start` with `stop` together in IDLE -> remains IDLE.
- SEL_W=1 and SEL_W=6, dwell=255: DIRECT decode is correct at the extremes (`in_sel`=63 -> bit 63). Each scan position lasts 256 cycles.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder / scan sequencer.
package decoder_pkg;

  localparam int DEC_MAX_SEL_W = 6;
  localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_SEL_W;

  localparam logic DEC_MODE_DIRECT = 1'b0;
  localparam logic DEC_MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_HOLD = 2'd1,
    DEC_SCAN = 2'd2
  } dec_state_e;

  // Sized for the widest legal decoder; callers truncate to their own width.
  function automatic logic [DEC_MAX_OUT_W-1:0] onehot(input logic [DEC_MAX_SEL_W-1:0] sel);
    return DEC_MAX_OUT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/decoder_dwell_timer.sv
// Dwell counter for the scan sequencer: counts 0..limit, then wraps to 0.
module decoder_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               run,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] limit;

  // The count stops at limit and restarts, so it can never overflow even at all-ones.
  assign tc = (cnt == limit);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      limit <= '0;
    end else if (load) begin
      cnt   <= '0;
      limit <= load_val;
    end else if (run) begin
      cnt <= tc ? '0 : cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with DIRECT (handshaked select) and SCAN (walking bit) modes.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               wrap,
  output logic               busy
);

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] s);
    return OUT_W'(onehot(DEC_MAX_SEL_W'(s)));
  endfunction

  dec_state_e       state, state_d;
  logic [OUT_W-1:0] out_d;
  logic [SEL_W-1:0] sel_d;
  logic             wrap_d;
  logic             t_clear, t_load, t_run, t_tc;

  decoder_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (t_clear),
    .load     (t_load),
    .load_val (dwell),
    .run      (t_run),
    .tc       (t_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DEC_IDLE;
      out     <= '0;
      cur_sel <= '0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_d;
      out     <= out_d;
      cur_sel <= sel_d;
      wrap    <= wrap_d;
    end
  end

  // Both flags decode the state register only, so they stay free of input paths.
  assign busy      = (state == DEC_SCAN);
  assign out_valid = (state != DEC_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state;
    out_d   = out;
    sel_d   = cur_sel;
    wrap_d  = 1'b0;
    t_clear = 1'b0;
    t_load  = 1'b0;
    t_run   = 1'b0;

    if (!enable) begin
      state_d = DEC_IDLE;
      out_d   = '0;
      sel_d   = '0;
      t_clear = 1'b1;
    end else begin
      unique case (state)
        DEC_IDLE: begin
          if (mode == DEC_MODE_DIRECT && in_valid) begin
            state_d = DEC_HOLD;
            out_d   = decode(in_sel);
            sel_d   = in_sel;
          end else if (mode == DEC_MODE_SCAN && start && !stop) begin
            state_d = DEC_SCAN;
            out_d   = decode('0);
            sel_d   = '0;
            t_load  = 1'b1;
          end
        end
        DEC_HOLD: begin
          if (in_valid) begin
            out_d = decode(in_sel);
            sel_d = in_sel;
          end else if (mode == DEC_MODE_SCAN) begin
            state_d = DEC_IDLE;
            out_d   = '0;
            sel_d   = '0;
          end
        end
        DEC_SCAN: begin
          // Stop outranks the terminal-count advance, which also suppresses wrap.
          if (stop) begin
            state_d = DEC_IDLE;
            out_d   = '0;
            sel_d   = '0;
            t_clear = 1'b1;
          end else begin
            t_run = 1'b1;
            if (t_tc) begin
              sel_d  = cur_sel + SEL_W'(1);
              out_d  = decode(cur_sel + SEL_W'(1));
              wrap_d = &cur_sel;
            end
          end
        end
        default: begin
          state_d = DEC_IDLE;
          out_d   = '0;
          sel_d   = '0;
        end
      endcase
    end
  end

endmodule
